// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Fills program/data memory from a byte stream while the CPU core is held
//   in reset. It then reads the written region back, compares an XOR
//   checksum of the read data with one taken on the way in, and releases the
//   core only when the two match.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        single-cycle load request (honoured in IDLE/DONE only)
//   start_addr   first address to write (captured on start)
//   length       number of bytes to load (captured on start)
//   s_valid      stream byte valid
//   s_data       stream byte
//   s_ready      loader accepts a byte (WRITE state)
//   mem_we       memory write enable (valid & ready)
//   mem_addr     memory address
//   mem_din      memory write data
//   mem_dout     memory read data, one cycle after the address
//   busy         WRITE / VERIFY / CHECK
//   done         DONE state
//   error        verify mismatch, meaningful while done=1
//   checksum     XOR of every accepted byte
//   cpu_reset_n  core reset, released only in DONE without error
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  cpu_reset_n
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_base;     // captured start_addr, reused for verify
    logic [ADDR_WIDTH-1:0] r_len;      // captured length, reused for verify
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_rem;      // bytes still to write / addresses still to issue
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [DATA_WIDTH-1:0] r_vsum;
    logic                  r_rd_vld;   // a read was issued last cycle; fold mem_dout now
    logic                  r_error;

    logic                  w_start;
    logic                  w_hs;
    logic                  w_last_wr;
    logic                  w_issue;

    assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hs      = (r_state == S_WRITE) && s_valid;
    assign w_last_wr = w_hs && (r_rem == ADDR_WIDTH'(1));
    // In VERIFY, r_rem counts addresses not yet issued; the cycle with
    // r_rem==0 exists only to fold the final read.
    assign w_issue   = (r_state == S_VERIFY) && (r_rem != '0);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        busy        = 1'b0;
        done        = 1'b0;
        cpu_reset_n = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (length != '0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                s_ready  = 1'b1;
                mem_we   = s_valid;
                mem_addr = r_ptr;
                mem_din  = s_data;
                if (w_last_wr) begin
                    w_state_nxt = S_VERIFY;
                end
            end
            S_VERIFY: begin
                busy     = 1'b1;
                mem_addr = r_ptr;
                if (r_rem == '0) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                cpu_reset_n = ~r_error;
                if (start) begin
                    w_state_nxt = (length != '0) ? S_WRITE : S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: pointers, counters, checksums
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_ptr      <= '0;
            r_rem      <= '0;
            r_checksum <= '0;
            r_vsum     <= '0;
            r_rd_vld   <= 1'b0;
            r_error    <= 1'b0;
        end else if (w_start) begin
            r_base     <= start_addr;
            r_len      <= length;
            r_ptr      <= start_addr;
            r_rem      <= length;
            r_checksum <= '0;
            r_vsum     <= '0;
            r_rd_vld   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_checksum <= r_checksum ^ s_data;
                if (w_last_wr) begin
                    // Rewind for the read-back pass.
                    r_ptr <= r_base;
                    r_rem <= r_len;
                end else begin
                    r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    r_rem <= r_rem - ADDR_WIDTH'(1);
                end
            end

            if (r_state == S_VERIFY) begin
                r_rd_vld <= w_issue;
                if (r_rd_vld) begin
                    r_vsum <= r_vsum ^ mem_dout;
                end
                if (w_issue) begin
                    r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    r_rem <= r_rem - ADDR_WIDTH'(1);
                end
            end

            if (r_state == S_CHECK) begin
                r_error <= (r_vsum != r_checksum);
            end
        end
    end

    assign error    = r_error;
    assign checksum = r_checksum;

endmodule
